// File: rtl/alu_pkg.sv
// Opcode map, sequencer states and flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_MUL   = 5'd2;
  localparam logic [4:0] OP_RDHI  = 5'd3;
  localparam logic [4:0] OP_DIV   = 5'd4;
  localparam logic [4:0] OP_RDREM = 5'd5;
  localparam logic [4:0] OP_INC   = 5'd6;
  localparam logic [4:0] OP_DEC   = 5'd7;
  localparam logic [4:0] OP_AND   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_NOT   = 5'd11;
  localparam logic [4:0] OP_NEG   = 5'd12;
  localparam logic [4:0] OP_LSL   = 5'd13;
  localparam logic [4:0] OP_LSR   = 5'd14;
  localparam logic [4:0] OP_ZEROS = 5'd15;
  localparam logic [4:0] OP_ONES  = 5'd16;
  localparam logic [4:0] OP_PASSR = 5'd17;
  localparam logic [4:0] OP_PASSS = 5'd18;
  localparam logic [4:0] OP_ASR   = 5'd19;
  localparam logic [4:0] OP_NEG2  = 5'd20;
  localparam logic [4:0] OP_ASL   = 5'd21;
  localparam logic [4:0] OP_NOT2  = 5'd22;
  localparam logic [4:0] OP_ROR   = 5'd23;
  localparam logic [4:0] OP_ROL   = 5'd24;
  localparam logic [4:0] OP_MULU  = 5'd25;
  localparam logic [4:0] OP_DIVU  = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register file side and the sequential ALU.
interface alu_seq_if #(
  parameter int W = 64
);
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] r;
  logic [W-1:0] s;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         n;
  logic         z;
  logic         c;
  logic         v;
  logic         dz;

  modport master (
    output start, op, r, s,
    input  busy, done, y, y_hi, n, z, c, v, dz
  );

  modport slave (
    input  start, op, r, s,
    output busy, done, y, y_hi, n, z, c, v, dz
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned-magnitude shift-add multiplier / restoring divider, W steps per op.
// Signs are stripped at start and reported back so the caller can fix the result.
module alu_seq_muldiv #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_mul_i,
  input  logic         start_div_i,
  input  logic         sgn_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         last_o,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         neg_lo_o,
  output logic         neg_hi_o
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, div_q, div_d, nlo_q, nlo_d, nhi_q, nhi_d;
  logic          a_neg, b_neg, last;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    acc, rem_ext, trial;

  always_comb begin
    a_neg   = sgn_i & a_i[W-1];
    b_neg   = sgn_i & b_i[W-1];
    a_mag   = a_neg ? -a_i : a_i;
    b_mag   = b_neg ? -b_i : b_i;
    last    = run_q && (cnt_q == CW'(W - 1));
    acc     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W + 1){1'b0}});
    rem_ext = {hi_q, lo_q[W-1]};
    trial   = rem_ext - {1'b0, b_q};

    lo_d  = lo_q;
    hi_d  = hi_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    nlo_d = nlo_q;
    nhi_d = nhi_q;

    if (start_mul_i || start_div_i) begin
      lo_d  = a_mag;
      hi_d  = '0;
      b_d   = b_mag;
      cnt_d = '0;
      run_d = 1'b1;
      div_d = start_div_i;
      nlo_d = a_neg ^ b_neg;
      nhi_d = a_neg;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      run_d = !last;
      if (div_q) begin
        // Quotient bits shift into lo as the dividend shifts out into the remainder.
        if (!trial[W]) begin
          hi_d = trial[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = rem_ext[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = acc[W:1];
        lo_d = {acc[0], lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
      nlo_q <= 1'b0;
      nhi_q <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
      nlo_q <= nlo_d;
      nhi_q <= nhi_d;
    end
  end

  assign busy_o   = run_q;
  assign last_o   = last;
  assign lo_o     = lo_q;
  assign hi_o     = hi_q;
  assign neg_lo_o = nlo_q;
  assign neg_hi_o = nhi_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential W-bit ALU: single-cycle ops done one cycle after sampling, mul/div after W+1.
// No queueing: start is only sampled while busy=0; results hold until the next done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam logic [W-1:0] MIN_V = {1'b1, {(W - 1){1'b0}}};

  alu_state_t   state_q, state_d;
  logic [4:0]   op_q, op_d;
  logic [W-1:0] r_q, r_d, s_q, s_d;
  logic         pend_q, pend_d;
  logic [W-1:0] y_q, y_d, hi_q, hi_d;
  logic [3:0]   flags_q, flags_d;
  logic         dz_q, dz_d, done_q, done_d;

  logic         accept, op_mul, op_div, op_sgn, start_mul, start_div;
  logic         md_busy, md_last, md_neg_lo, md_neg_hi;
  logic [W-1:0] md_lo, md_hi;

  logic [W:0]     sum;
  logic [W-1:0]   sc_y;
  logic           sc_c, sc_v;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic           fix_div, div_ovf, latched_div;

  always_comb begin
    accept    = bus.start && (state_q == ST_IDLE);
    op_mul    = (bus.op == OP_MUL) || (bus.op == OP_MULU);
    op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_sgn    = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    start_mul = accept && op_mul;
    start_div = accept && op_div && (bus.s != '0);
  end

  alu_seq_muldiv #(.W(W)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_mul_i (start_mul),
    .start_div_i (start_div),
    .sgn_i       (op_sgn),
    .a_i         (bus.r),
    .b_i         (bus.s),
    .busy_o      (md_busy),
    .last_o      (md_last),
    .lo_o        (md_lo),
    .hi_o        (md_hi),
    .neg_lo_o    (md_neg_lo),
    .neg_hi_o    (md_neg_hi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mul)      state_d = ST_MUL;
        else if (start_div) state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (md_last)       state_d = ST_FIX;
        else if (!md_busy) state_d = ST_IDLE;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    op_d   = accept ? bus.op : op_q;
    r_d    = accept ? bus.r : r_q;
    s_d    = accept ? bus.s : s_q;
    pend_d = accept && !start_mul && !start_div;
  end

  // Unary and shift ops act on s; a div reaching this path always has s == 0.
  always_comb begin
    sum  = '0;
    sc_y = s_q;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum  = {1'b0, r_q} + {1'b0, s_q};
        sc_y = sum[W-1:0];
        sc_c = sum[W];
        sc_v = (r_q[W-1] == s_q[W-1]) && (sc_y[W-1] != r_q[W-1]);
      end
      OP_SUB: begin
        sc_y = r_q - s_q;
        sc_c = (r_q < s_q);
        sc_v = (r_q[W-1] != s_q[W-1]) && (sc_y[W-1] != r_q[W-1]);
      end
      OP_RDHI, OP_RDREM: sc_y = hi_q;
      OP_DIV, OP_DIVU: begin
        sc_y = '1;
        sc_v = 1'b1;
      end
      OP_INC: begin
        sc_y = s_q + W'(1);
        sc_v = sc_y[W-1] & ~s_q[W-1];
      end
      OP_DEC: begin
        sc_y = s_q - W'(1);
        sc_v = ~sc_y[W-1] & s_q[W-1];
      end
      OP_AND:           sc_y = r_q & s_q;
      OP_OR:            sc_y = r_q | s_q;
      OP_XOR:           sc_y = r_q ^ s_q;
      OP_NOT, OP_NOT2:  sc_y = ~s_q;
      OP_NEG, OP_NEG2:  sc_y = -s_q;
      OP_LSL: begin
        sc_y = {s_q[W-2:0], 1'b0};
        sc_c = s_q[W-1];
      end
      OP_LSR: begin
        sc_y = {1'b0, s_q[W-1:1]};
        sc_c = s_q[0];
      end
      OP_ZEROS:         sc_y = '0;
      OP_ONES:          sc_y = '1;
      OP_PASSR:         sc_y = r_q;
      OP_ASR:           sc_y = {s_q[W-1], s_q[W-1:1]};
      OP_ASL: begin
        sc_y = {s_q[W-2:0], 1'b0};
        sc_c = s_q[W-1];
        sc_v = sc_y[W-1] != s_q[W-1];
      end
      OP_ROR:           sc_y = {s_q[0], s_q[W-1:1]};
      OP_ROL:           sc_y = {s_q[W-2:0], s_q[W-1]};
      default:          sc_y = s_q;
    endcase
  end

  always_comb begin
    prod        = md_neg_lo ? -{md_hi, md_lo} : {md_hi, md_lo};
    quo         = md_neg_lo ? -md_lo : md_lo;
    rem         = md_neg_hi ? -md_hi : md_hi;
    fix_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    latched_div = fix_div;
    div_ovf     = (op_q == OP_DIV) && (r_q == MIN_V) && (s_q == '1);

    y_d     = y_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    if (pend_q) begin
      done_d          = 1'b1;
      y_d             = sc_y;
      flags_d[FLAG_C] = sc_c;
      flags_d[FLAG_V] = sc_v;
      if (latched_div) begin
        hi_d = r_q;
        dz_d = 1'b1;
      end
    end else if (state_q == ST_FIX) begin
      done_d          = 1'b1;
      flags_d[FLAG_C] = 1'b0;
      if (fix_div) begin
        y_d             = quo;
        hi_d            = rem;
        dz_d            = 1'b0;
        flags_d[FLAG_V] = div_ovf;
      end else begin
        y_d             = prod[W-1:0];
        hi_d            = prod[2*W-1:W];
        flags_d[FLAG_V] = (op_q == OP_MUL) ? (prod[2*W-1:W] != {W{prod[W-1]}})
                                           : (prod[2*W-1:W] != '0);
      end
    end

    if (done_d) begin
      flags_d[FLAG_N] = y_d[W-1];
      flags_d[FLAG_Z] = (y_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      pend_q  <= 1'b0;
      y_q     <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      s_q     <= s_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.y_hi = hi_q;
  assign bus.n    = flags_q[FLAG_N];
  assign bus.z    = flags_q[FLAG_Z];
  assign bus.c    = flags_q[FLAG_C];
  assign bus.v    = flags_q[FLAG_V];
  assign bus.dz   = dz_q;

endmodule
